// File: rtl/cbus_rr_arbiter_if.sv
// rtl/cbus_rr_arbiter_if.sv - cbus transaction types and the arbiter port bundle
package cbus_pkg;
    localparam int LEN_W = 4;

    typedef struct packed {
        logic             valid;
        logic             write;
        logic [15:0]      addr;
        logic [31:0]      wdata;
        logic [LEN_W-1:0] len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;
endpackage

interface cbus_rr_arbiter_if #(
    parameter int NUM_INPUTS = 2
);
    import cbus_pkg::*;

    localparam int ID_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    cbus_req_t  [NUM_INPUTS-1:0] ireqs;
    cbus_resp_t [NUM_INPUTS-1:0] iresps;
    cbus_req_t                   oreq;
    cbus_resp_t                  oresp;
    logic                        busy;
    logic [ID_W-1:0]             grant_id;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq,
        output busy,
        output grant_id
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq,
        input  busy,
        input  grant_id
    );
endinterface

// File: rtl/cbus_rr_arbiter.sv
// rtl/cbus_rr_arbiter.sv - round-robin arbiter granting one cbus master per burst
module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic               clk,
    input  logic               resetn,
    cbus_rr_arbiter_if.slave   bus
);
    localparam int ID_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   sel_q, sel_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [LEN_W-1:0]  beat_q, beat_d;

    logic              any_valid;
    logic [ID_W-1:0]   pick;
    int                idx;

    // Search starts just after the previous winner and wraps, giving rotating priority.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_INPUTS) begin
                idx = idx - NUM_INPUTS;
            end
            if (!any_valid && bus.ireqs[idx].valid) begin
                any_valid = 1'b1;
                pick      = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        beat_d       = beat_q;
        bus.oreq     = '0;
        bus.iresps   = '0;
        bus.busy     = 1'b0;
        bus.grant_id = '0;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    sel_d   = pick;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.oreq            = bus.ireqs[sel_q];
                bus.iresps[sel_q]   = bus.oresp;
                bus.busy            = 1'b1;
                bus.grant_id        = sel_q;
                if (bus.oresp.ready) begin
                    if (bus.oresp.last) begin
                        state_d = IDLE;
                        last_d  = sel_q;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= ID_W'(NUM_INPUTS - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb/tb_cbus_rr_arbiter.sv - directed vector bench for cbus_rr_arbiter
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn2;
    logic rn4;

    cbus_rr_arbiter_if #(.NUM_INPUTS(2)) b2();
    cbus_rr_arbiter_if #(.NUM_INPUTS(4)) b4();

    cbus_rr_arbiter #(.NUM_INPUTS(2)) u_dut2 (.clk(clk), .resetn(rn2), .bus(b2.slave));
    cbus_rr_arbiter #(.NUM_INPUTS(4)) u_dut4 (.clk(clk), .resetn(rn4), .bus(b4.slave));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rn, v0, v1, rdy, lst;
        logic        ov;
        logic [15:0] addr;
        logic        bsy, gid, r0, r1;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic rn, input logic v0, input logic v1,
                          input logic [3:0] l0, input logic [3:0] l1,
                          input logic rdy, input logic lst);
        rn2                 = rn;
        b2.ireqs[0].valid   = v0;
        b2.ireqs[0].len     = l0;
        b2.ireqs[1].valid   = v1;
        b2.ireqs[1].len     = l1;
        b2.oresp.ready      = rdy;
        b2.oresp.last       = lst;
    endtask

    function automatic logic [63:0] obs2();
        return {43'd0, b2.oreq.valid, b2.oreq.addr, b2.busy, b2.grant_id,
                b2.iresps[0].ready, b2.iresps[1].ready};
    endfunction

    function automatic logic [63:0] exp2(input logic ov, input logic [15:0] addr,
                                         input logic bsy, input logic gid,
                                         input logic r0, input logic r1);
        return {43'd0, ov, addr, bsy, gid, r0, r1};
    endfunction

    function automatic vec_t mk(input logic rn, input logic v0, input logic v1,
                                input logic rdy, input logic lst, input logic ov,
                                input logic [15:0] addr, input logic bsy,
                                input logic gid, input logic r0, input logic r1);
        vec_t v;
        v.rn = rn; v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.lst = lst;
        v.ov = ov; v.addr = addr; v.bsy = bsy; v.gid = gid; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    initial begin
        logic [1:0] order[5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

        // rn v0 v1 rdy lst | oreq.valid addr busy gid r0 r1
        tbl[0]  = mk(0, 1, 1, 1, 1,  0, 16'h0000, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1, 1, 1,  1, 16'hA001, 1, 1, 0, 1);
        tbl[3]  = mk(1, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 1, 1,  0, 16'h0000, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[7]  = mk(1, 1, 1, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[8]  = mk(1, 1, 1, 1, 1,  1, 16'hA000, 1, 0, 1, 0);
        tbl[9]  = mk(1, 1, 1, 1, 1,  0, 16'h0000, 0, 0, 0, 0);
        tbl[10] = mk(1, 1, 1, 1, 1,  1, 16'hA001, 1, 1, 0, 1);
        tbl[11] = mk(1, 1, 1, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
        tbl[12] = mk(1, 1, 1, 1, 1,  1, 16'hA000, 1, 0, 1, 0);
        tbl[13] = mk(1, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);

        b2.ireqs = '0;
        b2.oresp = '0;
        b4.ireqs = '0;
        b4.oresp = '0;
        for (int i = 0; i < 2; i++) begin
            b2.ireqs[i].addr  = 16'hA000 + 16'(i);
            b2.ireqs[i].wdata = 32'hC0DE_0000 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            b4.ireqs[i].addr = 16'hB000 + 16'(i);
        end
        b2.oresp.rdata = 32'h1234_5678;
        rn4 = 1'b0;
        drive2(0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;

        for (int i = 0; i < 14; i++) begin
            drive2(tbl[i].rn, tbl[i].v0, tbl[i].v1, 4'd0, 4'd0, tbl[i].rdy, tbl[i].lst);
            #3;
            chk($sformatf("vec%0d", i), obs2(),
                exp2(tbl[i].ov, tbl[i].addr, tbl[i].bsy, tbl[i].gid, tbl[i].r0, tbl[i].r1));
            tick;
        end

        // Burst hold: master 0, len=3, four beats with a stall; master 1 keeps requesting
        drive2(0, 0, 0, 0, 0, 0, 0);
        tick;
        drive2(1, 1, 1, 4'd3, 4'd0, 0, 0);
        #3;
        chk("burst_idle", 64'(b2.busy), 64'd0);
        tick;
        for (int b = 0; b < 3; b++) begin
            drive2(1, 1, 1, 4'd3, 4'd0, 1, 0);
            #3;
            chk($sformatf("burst_beat%0d", b),
                {b2.oreq.valid, b2.oreq.addr, b2.oreq.len, b2.grant_id,
                 b2.iresps[0].ready, (b2.iresps[1] == '0)},
                {1'b1, 16'hA000, 4'd3, 1'b0, 1'b1, 1'b1});
            chk($sformatf("burst_rdata%0d", b), 64'(b2.iresps[0].rdata), 64'h1234_5678);
            tick;
            if (b == 0) begin
                drive2(1, 1, 1, 4'd3, 4'd0, 0, 0);
                #3;
                chk("burst_stall", {b2.busy, b2.grant_id, b2.iresps[0].ready},
                    {1'b1, 1'b0, 1'b0});
                tick;
            end
        end
        drive2(1, 1, 1, 4'd3, 4'd0, 1, 1);
        #3;
        chk("burst_beat_cnt", 64'(u_dut2.beat_q), 64'd3);
        chk("burst_last", {b2.oreq.valid, b2.oreq.addr, (b2.iresps[1] == '0)},
            {1'b1, 16'hA000, 1'b1});
        tick;
        drive2(1, 0, 1, 4'd0, 4'd0, 0, 0);
        #3;
        chk("burst_gap", {b2.oreq.valid, b2.busy}, 2'b00);
        tick;
        drive2(1, 0, 1, 4'd0, 4'd0, 1, 1);
        #3;
        chk("burst_next", {b2.busy, b2.grant_id, b2.oreq.addr}, {1'b1, 1'b1, 16'hA001});
        tick;

        // Reset during beat 2 of a burst on master 1
        drive2(0, 0, 0, 0, 0, 0, 0);
        tick;
        drive2(1, 0, 1, 4'd0, 4'd3, 0, 0);
        tick;
        drive2(1, 0, 1, 4'd0, 4'd3, 1, 0);
        #3;
        chk("rst_beat1", {b2.busy, b2.grant_id}, 2'b11);
        tick;
        drive2(0, 0, 1, 4'd0, 4'd3, 1, 0);
        tick;
        drive2(1, 1, 1, 4'd0, 4'd0, 0, 0);
        #3;
        chk("rst_abort", {b2.oreq.valid, b2.busy, b2.grant_id, (b2.iresps == '0)},
            {1'b0, 1'b0, 1'b0, 1'b1});
        tick;
        #3;
        chk("rst_regrant", {b2.busy, b2.grant_id, b2.oreq.addr}, {1'b1, 1'b0, 16'hA000});
        drive2(1, 0, 0, 0, 0, 1, 1);
        tick;

        // Fairness on the four-master instance, all requesting continuously
        rn4 = 1'b0;
        tick;
        rn4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b4.ireqs[i].valid = 1'b1;
        end
        b4.oresp = '0;
        for (int k = 0; k < 5; k++) begin
            b4.oresp.ready = 1'b0;
            b4.oresp.last  = 1'b0;
            #3;
            chk($sformatf("fair_idle%0d", k), {b4.busy, b4.grant_id, b4.oreq.valid}, 4'd0);
            tick;
            b4.oresp.ready = 1'b1;
            b4.oresp.last  = 1'b1;
            #3;
            chk($sformatf("fair_grant%0d", k), {b4.busy, b4.grant_id, b4.oreq.addr},
                {1'b1, order[k], 16'hB000 + 16'(order[k])});
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
